// File: rtl/spi_display_pkg.sv
// rtl/spi_display_pkg.sv - shared opcodes, codes, states and colour helpers for the SPI display decoder
package spi_display_pkg;

    localparam logic [7:0] OP_SWRESET = 8'h01;
    localparam logic [7:0] OP_DISPOFF = 8'h28;
    localparam logic [7:0] OP_DISPON  = 8'h29;
    localparam logic [7:0] OP_CASET   = 8'h2A;
    localparam logic [7:0] OP_PASET   = 8'h2B;
    localparam logic [7:0] OP_RAMWR   = 8'h2C;
    localparam logic [7:0] OP_MADCTL  = 8'h36;
    localparam logic [7:0] OP_COLMOD  = 8'h3A;
    localparam logic [7:0] OP_RAMWRC  = 8'h3C;

    localparam logic [3:0] COLMOD_565 = 4'h5;
    localparam logic [3:0] COLMOD_666 = 4'h6;

    localparam int MADCTL_MY = 7;
    localparam int MADCTL_MX = 6;
    localparam int MADCTL_MV = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PARAM,
        ST_WRITE
    } state_e;

    // Replicate the channel MSBs into the low bits so full-scale inputs map to 0xFF.
    function automatic logic [23:0] expand565(input logic [15:0] w);
        return {w[15:11], w[15:13], w[10:5], w[10:9], w[4:0], w[4:2]};
    endfunction

    function automatic logic [23:0] expand666(input logic [7:0] r, input logic [7:0] g,
                                              input logic [7:0] b);
        return {r[7:2], r[7:6], g[7:2], g[7:6], b[7:2], b[7:6]};
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - synchronous pixel FIFO with flush and same-cycle push/pop
module pixel_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 56
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic          empty,
    output logic          full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic [DW-1:0] mem_q [DEPTH];
    logic          do_push, do_pop;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop    = pop & ~empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push   = push & (~full | do_pop) & ~flush;
    assign head_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/spi_display_ctrl.sv
// rtl/spi_display_ctrl.sv - ILI9340-subset command decoder producing mapped pixels into a FIFO
module spi_display_ctrl
    import spi_display_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int X_RES      = 1024,
    parameter int Y_RES      = 768,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cs,
    input  logic             rx_strobe,
    input  logic [7:0]       rx_data,
    input  logic             rx_dc,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic [WIDTH-1:0] pix_x,
    output logic [WIDTH-1:0] pix_y,
    output logic [23:0]      pix_data,
    output logic             display_on,
    output logic             overflow,
    output logic [WIDTH-1:0] x_start,
    output logic [WIDTH-1:0] x_end,
    output logic [WIDTH-1:0] y_start,
    output logic [WIDTH-1:0] y_end
);
    localparam int               FW      = 2 * WIDTH + 24;
    localparam logic [WIDTH-1:0] X_MAX   = WIDTH'(X_RES - 1);
    localparam logic [WIDTH-1:0] Y_MAX   = WIDTH'(Y_RES - 1);
    localparam logic [15:0]      X_MAX16 = 16'(X_RES - 1);
    localparam logic [15:0]      Y_MAX16 = 16'(Y_RES - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    state_e           state_q, state_d;
    logic [7:0]       opcode_q, opcode_d;
    logic [2:0]       pcnt_q, pcnt_d;
    logic [23:0]      pbuf_q, pbuf_d;
    logic [1:0]       pixcnt_q, pixcnt_d;
    logic [15:0]      pixbuf_q, pixbuf_d;
    logic [WIDTH-1:0] xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
    logic [WIDTH-1:0] col_q, col_d, row_q, row_d;
    logic             mv_q, mv_d, mx_q, mx_d, my_q, my_d;
    logic             fmt666_q, fmt666_d;
    logic             disp_on_q, disp_on_d;
    logic             ovf_q, ovf_d;
    logic             cs_q;

    logic [15:0]      p_start, p_end, p_max, p_end_c;
    logic [WIDTH-1:0] lx, ly, map_x, map_y;
    logic             pix_done, fifo_flush, fifo_full, fifo_empty, fifo_pop;
    logic [23:0]      pix_rgb;
    logic [FW-1:0]    head;

    // The 4th window byte is combined directly from rx_data so the commit happens on its strobe.
    assign p_start = pbuf_q[23:8];
    assign p_end   = {pbuf_q[7:0], rx_data};
    assign p_max   = (opcode_q == OP_CASET) ? X_MAX16 : Y_MAX16;
    assign p_end_c = (p_end > p_max) ? p_max : p_end;

    always_comb begin
        lx    = mv_q ? row_q : col_q;
        ly    = mv_q ? col_q : row_q;
        map_x = mx_q ? X_MAX - lx : lx;
        map_y = my_q ? Y_MAX - ly : ly;
    end

    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        pcnt_d     = pcnt_q;
        pbuf_d     = pbuf_q;
        pixcnt_d   = pixcnt_q;
        pixbuf_d   = pixbuf_q;
        xs_d       = xs_q;
        xe_d       = xe_q;
        ys_d       = ys_q;
        ye_d       = ye_q;
        col_d      = col_q;
        row_d      = row_q;
        mv_d       = mv_q;
        mx_d       = mx_q;
        my_d       = my_q;
        fmt666_d   = fmt666_q;
        disp_on_d  = disp_on_q;
        ovf_d      = ovf_q;
        pix_done   = 1'b0;
        pix_rgb    = '0;
        fifo_flush = 1'b0;

        if (cs && !cs_q) begin
            state_d  = ST_IDLE;
            pcnt_d   = '0;
            pixcnt_d = '0;
        end else if (rx_strobe && !rx_dc) begin
            opcode_d = rx_data;
            pcnt_d   = '0;
            pixcnt_d = '0;
            state_d  = ST_IDLE;
            case (rx_data)
                OP_SWRESET: begin
                    xs_d       = '0;
                    xe_d       = X_MAX;
                    ys_d       = '0;
                    ye_d       = Y_MAX;
                    col_d      = '0;
                    row_d      = '0;
                    mv_d       = 1'b0;
                    mx_d       = 1'b0;
                    my_d       = 1'b0;
                    fmt666_d   = 1'b0;
                    disp_on_d  = 1'b0;
                    ovf_d      = 1'b0;
                    fifo_flush = 1'b1;
                end
                OP_DISPOFF: disp_on_d = 1'b0;
                OP_DISPON:  disp_on_d = 1'b1;
                OP_CASET, OP_PASET, OP_MADCTL, OP_COLMOD: state_d = ST_PARAM;
                OP_RAMWR: begin
                    col_d   = xs_q;
                    row_d   = ys_q;
                    state_d = ST_WRITE;
                end
                OP_RAMWRC: state_d = ST_WRITE;
                default: ;
            endcase
        end else if (rx_strobe) begin
            case (state_q)
                ST_PARAM: begin
                    if (pcnt_q != 3'd4) pcnt_d = pcnt_q + 3'd1;
                    pbuf_d = {pbuf_q[15:0], rx_data};
                    case (opcode_q)
                        OP_CASET, OP_PASET: begin
                            if (pcnt_q == 3'd3 && p_start <= p_end_c) begin
                                if (opcode_q == OP_CASET) begin
                                    xs_d = WIDTH'(p_start);
                                    xe_d = WIDTH'(p_end_c);
                                end else begin
                                    ys_d = WIDTH'(p_start);
                                    ye_d = WIDTH'(p_end_c);
                                end
                            end
                        end
                        OP_MADCTL: begin
                            if (pcnt_q == 3'd0) begin
                                my_d = rx_data[MADCTL_MY];
                                mx_d = rx_data[MADCTL_MX];
                                mv_d = rx_data[MADCTL_MV];
                            end
                        end
                        OP_COLMOD: begin
                            if (pcnt_q == 3'd0) begin
                                if (rx_data[3:0] == COLMOD_565)      fmt666_d = 1'b0;
                                else if (rx_data[3:0] == COLMOD_666) fmt666_d = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                ST_WRITE: begin
                    pixbuf_d = {pixbuf_q[7:0], rx_data};
                    if (!fmt666_q && pixcnt_q == 2'd1) begin
                        pix_done = 1'b1;
                        pix_rgb  = expand565({pixbuf_q[7:0], rx_data});
                        pixcnt_d = '0;
                    end else if (fmt666_q && pixcnt_q == 2'd2) begin
                        pix_done = 1'b1;
                        pix_rgb  = expand666(pixbuf_q[15:8], pixbuf_q[7:0], rx_data);
                        pixcnt_d = '0;
                    end else begin
                        pixcnt_d = pixcnt_q + 2'd1;
                    end
                end
                default: ;
            endcase
        end

        // A dropped pixel still consumes its slot in the window.
        if (pix_done) begin
            if (col_q != xe_q) begin
                col_d = col_q + ONE;
            end else begin
                col_d = xs_q;
                row_d = (row_q == ye_q) ? ys_q : row_q + ONE;
            end
            if (fifo_full && !fifo_pop) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            opcode_q  <= '0;
            pcnt_q    <= '0;
            pbuf_q    <= '0;
            pixcnt_q  <= '0;
            pixbuf_q  <= '0;
            xs_q      <= '0;
            xe_q      <= X_MAX;
            ys_q      <= '0;
            ye_q      <= Y_MAX;
            col_q     <= '0;
            row_q     <= '0;
            mv_q      <= 1'b0;
            mx_q      <= 1'b0;
            my_q      <= 1'b0;
            fmt666_q  <= 1'b0;
            disp_on_q <= 1'b0;
            ovf_q     <= 1'b0;
            cs_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            pcnt_q    <= pcnt_d;
            pbuf_q    <= pbuf_d;
            pixcnt_q  <= pixcnt_d;
            pixbuf_q  <= pixbuf_d;
            xs_q      <= xs_d;
            xe_q      <= xe_d;
            ys_q      <= ys_d;
            ye_q      <= ye_d;
            col_q     <= col_d;
            row_q     <= row_d;
            mv_q      <= mv_d;
            mx_q      <= mx_d;
            my_q      <= my_d;
            fmt666_q  <= fmt666_d;
            disp_on_q <= disp_on_d;
            ovf_q     <= ovf_d;
            cs_q      <= cs;
        end
    end

    assign fifo_pop = pix_valid & pix_ready;

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (FW)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (fifo_flush),
        .push      (pix_done),
        .push_data ({map_x, map_y, pix_rgb}),
        .pop       (fifo_pop),
        .head_data (head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign pix_valid  = ~fifo_empty;
    assign pix_x      = head[FW-1 -: WIDTH];
    assign pix_y      = head[FW-WIDTH-1 -: WIDTH];
    assign pix_data   = head[23:0];
    assign display_on = disp_on_q;
    assign overflow   = ovf_q;
    assign x_start    = xs_q;
    assign x_end      = xe_q;
    assign y_start    = ys_q;
    assign y_end      = ye_q;

endmodule

// File: doc/spi_display_ctrl.md
# spi_display_ctrl

Parametrised, single-clock successor to the SPI display command decoder. It consumes the synchronised byte stream from the SPI byte receiver and decodes a useful ILI9340 subset: address window, memory write/continue, pixel format, rotation/mirroring, display on/off and software reset. Completed pixels, with physical coordinates, go through an internal FIFO to the frame-buffer writer over a valid/ready handshake.

## Interface
Parameters:
- WIDTH, 16, coordinate width in bits
- X_RES, 1024, physical columns
- Y_RES, 768, physical rows
- FIFO_DEPTH, 4, pixel FIFO entries (power of two, at least 2)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- cs  in  1  chip select, already synchronised to clk; high = deselected
- rx_strobe  in  1  one-cycle pulse: rx_data/rx_dc valid
- rx_data  in  8  received byte
- rx_dc  in  1  0 = command byte, 1 = parameter/data byte
- pix_valid  out  1  FIFO head valid
- pix_ready  in  1  consumer accepts head
- pix_x  out  WIDTH  physical column of head
- pix_y  out  WIDTH  physical row of head
- pix_data  out  24  RGB888 of head
- display_on  out  1  set by 0x29, cleared by 0x28
- overflow  out  1  sticky: pixel dropped on full FIFO
- x_start, x_end, y_start, y_end  out  WIDTH  current logical window

## Operation
- Command byte (rx_dc=0): latch opcode, clear parameter count and partial pixel, then enter the state for that opcode.
- States: IDLE, PARAM (0x2A/0x2B/0x36/0x3A), WRITE (0x2C/0x3C). Unknown opcodes go to IDLE, and their data bytes are ignored.
- 0x2A/0x2B: four bytes, start_hi, start_lo, end_hi, end_lo. The window is committed only on the 4th byte. If end ≥ RES, clamp end to RES-1 (use X_RES or Y_RES for the axis). If start > end after clamping, discard the whole set and keep the previous window. Bytes beyond the 4th are ignored.
- 0x36 (MADCTL), one byte: bit7 MY, bit6 MX, bit5 MV. Other bits are ignored.
- 0x3A (COLMOD), one byte:
  - low nibble 5 selects RGB565, 2 bytes per pixel;
  - low nibble 6 selects RGB666, 3 bytes per pixel, top 6 bits of each byte used;
  - any other value leaves the format unchanged.
- 0x2C: reset the logical position (col,row) to (x_start,y_start), then stream pixels. 0x3C: stream from the current position.
- Position advance on every completed pixel: col++ while col≠x_end. Otherwise col=x_start and row++, except that row wraps to y_start when row=y_end.
- Colour expansion:
  - 565: R={r5,r5[4:2]}, G={g6,g6[5:4]}, B={b5,b5[4:2]}.
  - 666: each channel is {c6,c6[5:4]}.
- Coordinate mapping, in this order:
  - MV: swap (col,row) to (row,col);
  - MX: x=X_RES-1-x;
  - MY: y=Y_RES-1-y.
- Full FIFO on pixel completion: drop the pixel, set overflow, still advance the position. A push is accepted if a pop occurs in the same cycle.
- cs rising: discard the partial pixel or partial parameter set and return to IDLE. Window, MADCTL, COLMOD and position are retained.
- 0x01 software reset: restore reset defaults and flush the FIFO.
- Reset values:
  - window (0,0)-(X_RES-1,Y_RES-1); position (0,0);
  - MADCTL 0, COLMOD 565;
  - display_on 0, overflow 0;
  - FIFO empty, pix_valid 0, pix_x/pix_y/pix_data 0;
  - state IDLE.

## Timing
- rx_strobe may be asserted on consecutive cycles. Every strobe is consumed in the cycle it arrives.
- Latency: final pixel byte strobe at cycle N gives pix_valid at N+1 when the FIFO was empty.
- Handshake: pop on pix_valid & pix_ready. Head data is stable while pix_valid=1 and pix_ready=0.
- Window registers update in the cycle after the 4th parameter byte. MADCTL and COLMOD apply to pixels completed after their byte.
- reset_n asserted mid-stream: all state clears immediately (asynchronously). No pixel is emitted until a new 0x2C/0x3C.

## Structure
- Shared package spi_display_pkg:
  - opcode constants (0x01, 0x28, 0x29, 0x2A, 0x2B, 0x2C, 0x36, 0x3A, 0x3C);
  - COLMOD codes;
  - MADCTL bit indices;
  - state enum.
- Sub-module pixel_fifo: synchronous FIFO, FIFO_DEPTH × (2·WIDTH+24), with full/empty flags and same-cycle push/pop.

## Test plan
- Window: 0x2A 00 10 00 12, 0x2B 00 05 00 06, 0x2C, then six 565 pixels F800 → coordinates (16..18,5) then (16..18,6); pix_data FF0000.
- Wrap and rotation: 0x36 20, window 0..1 × 0..0, 0x2C, three pixels → (0,0),(0,1),(0,0) physical. Repeat with 0x36 40 → x = X_RES-1, X_RES-2, X_RES-1.
- Format: 0x3A 66, 0x2C, bytes FC 00 FC → pix_data FF00FF. Then deassert cs after one byte of the next pixel → no pixel emitted.
- Backpressure: pix_ready=0, write FIFO_DEPTH+2 pixels → FIFO_DEPTH emitted in order, overflow=1. The next pixel after draining lands at position FIFO_DEPTH+2.
- Bad window: 0x2A 00 20 00 10 → window unchanged. 0x2A 07 FF 07 FF with X_RES=1024 → x_end=1023, and start 2047 > end, so the set is discarded.
- Reset: 0x29 → display_on=1; 0x01 → display_on=0, overflow=0, FIFO empty. reset_n low mid-pixel → all outputs at reset values.
